// File: rtl/demo_burst_driver.sv
// Burst bus driver: issues N read or write transfers from an internal word buffer
// through a bus master's device-side port, with per-phase handshake timeout.
module demo_burst_driver #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int BUF_AW         = 5,
    parameter int RD_OFFSET      = 16,
    parameter int ADDR_STRIDE    = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [BUF_AW:0]       burst_len,
    input  logic                  host_we,
    input  logic [BUF_AW-1:0]     host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_rw_mode,
    output logic                  m_valid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ready,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [BUF_AW:0]       xfer_cnt
);

    localparam int DEPTH = 2 ** BUF_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]         T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BUF_AW-1:0]     RD_OFF = BUF_AW'(RD_OFFSET % DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]            state;
    logic                  start_prev;
    logic                  armed;
    logic                  mode_r;
    logic [ADDR_WIDTH-1:0] addr_acc;
    logic [BUF_AW:0]       len_r;
    logic [BUF_AW-1:0]     idx;
    logic [BUF_AW-1:0]     rd_idx;
    logic [TW-1:0]         phase_cnt;
    logic [BUF_AW:0]       cnt_next;
    logic                  launch;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // armed blocks a launch until start has been seen high after reset, so a
    // button held low across reset release is not mistaken for a fresh press.
    assign launch   = (state == S_IDLE) && armed && start_prev && !start;
    assign cnt_next = xfer_cnt + {{BUF_AW{1'b0}}, 1'b1};
    assign rd_idx   = idx + RD_OFF;

    assign ready = (state == S_IDLE);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

    // addr_acc steps by STRIDE per transfer, equal to base + idx*STRIDE mod 2**ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            start_prev <= 1'b1;
            armed      <= 1'b0;
            mode_r     <= 1'b0;
            addr_acc   <= '0;
            len_r      <= '0;
            idx        <= '0;
            phase_cnt  <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_rw_mode  <= 1'b0;
            m_valid    <= 1'b0;
            error      <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            start_prev <= start;
            if (start) armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        mode_r   <= mode;
                        addr_acc <= base_addr;
                        len_r    <= burst_len;
                        xfer_cnt <= '0;
                        error    <= 1'b0;
                        idx      <= '0;
                        state    <= (burst_len == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    m_addr    <= addr_acc;
                    if (mode_r) m_wdata <= mem[idx];
                    m_rw_mode <= mode_r;
                    m_valid   <= 1'b1;
                    phase_cnt <= '0;
                    state     <= S_REQ;
                end
                S_REQ: begin
                    if (!m_ready) begin
                        m_valid   <= 1'b0;
                        phase_cnt <= '0;
                        state     <= S_WAIT;
                    end else if (phase_cnt == T_LAST) begin
                        error   <= 1'b1;
                        m_valid <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (m_ready) begin
                        state <= S_STORE;
                    end else if (phase_cnt == T_LAST) begin
                        error <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    xfer_cnt <= cnt_next;
                    idx      <= idx + 1'b1;
                    addr_acc <= addr_acc + STRIDE;
                    state    <= (cnt_next == len_r) ? S_DONE : S_LOAD;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_IDLE && host_we)
                mem[host_addr] <= host_wdata;
            else if (state == S_STORE && !mode_r)
                mem[rd_idx] <= m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) host_rdata <= '0;
        else     host_rdata <= mem[host_addr];
    end

endmodule

// File: tb/tb_demo_burst_driver.sv
// Directed bench for demo_burst_driver with a reactive bus master model.
module tb_demo_burst_driver;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int BAW = 5;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [BAW:0]  burst_len = '0;
    logic          host_we = 1'b0;
    logic [BAW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rw_mode;
    logic          m_valid;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b1;
    logic          ready, busy, done, error;
    logic [BAW:0]  xfer_cnt;

    int total = 0;
    int bad = 0;

    demo_burst_driver #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_AW(BAW), .RD_OFFSET(16),
        .ADDR_STRIDE(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .burst_len(burst_len), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rw_mode(m_rw_mode), .m_valid(m_valid),
        .m_rdata(m_rdata), .m_ready(m_ready), .ready(ready), .busy(busy),
        .done(done), .error(error), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Master model: ms_mode 0 = responsive (drop ready one cycle after valid,
    // restore it 3 cycles later with next read word), 1 = ready stuck high.
    int            ms_mode = 0;
    int            hold = 0;
    int            log_n = 0;
    int            rd_ptr = 0;
    int            done_cnt = 0;
    int            vcnt = 0;
    logic [AW-1:0] log_addr [256];
    logic [DW-1:0] log_wdata [256];
    logic          log_rw [256];
    logic [DW-1:0] rd_tab [64];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (m_valid) vcnt++;
        if (ms_mode == 1) begin
            m_ready = 1'b1;
        end else if (m_ready && m_valid) begin
            m_ready = 1'b0;
            hold = 3;
            log_addr[log_n % 256]  = m_addr;
            log_wdata[log_n % 256] = m_wdata;
            log_rw[log_n % 256]    = m_rw_mode;
            log_n++;
        end else if (!m_ready) begin
            hold--;
            if (hold <= 0) begin
                m_ready = 1'b1;
                m_rdata = rd_tab[rd_ptr % 64];
                rd_ptr++;
            end
        end
    end

    task automatic host_write(input logic [BAW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [BAW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        d = host_rdata;
    endtask

    // Launch a burst, wait (bounded) for its done pulse; dn = done pulses seen.
    task automatic run_burst(input logic m, input logic [AW-1:0] b,
                             input logic [BAW:0] l, output int dn);
        int dc0;
        dc0 = done_cnt;
        @(negedge clk);
        mode = m; base_addr = b; burst_len = l; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != dc0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        dn = done_cnt - dc0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        total++; if (xfer_cnt !== 6'd0) begin bad++; $display("FAIL reset_xfer: got %0d want 0", xfer_cnt); end
        total++; if (m_addr !== 16'h0) begin bad++; $display("FAIL reset_maddr: got %h want 0000", m_addr); end
        total++; if (host_rdata !== 8'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 00", host_rdata); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (ready !== 1'b1 || vcnt !== 0) begin
            bad++; $display("FAIL reset_held_start: ready=%b vcnt=%0d want ready=1 vcnt=0", ready, vcnt);
        end
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst();
        int dn; int l0;
        logic [DW-1:0] wd [4];
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
        for (int i = 0; i < 4; i++) host_write(BAW'(i), wd[i]);
        l0 = log_n;
        run_burst(1'b1, 16'h4001, 6'd4, dn);
        total++; if (dn !== 1) begin bad++; $display("FAIL wr_done: got %0d pulses want 1", dn); end
        total++; if (log_n - l0 !== 4) begin bad++; $display("FAIL wr_count: got %0d xfers want 4", log_n - l0); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_addr[l0+i] !== 16'h4001 + 16'(i) || log_wdata[l0+i] !== wd[i] || log_rw[l0+i] !== 1'b1) begin
                bad++;
                $display("FAIL wr_xfer%0d: got addr=%h data=%h rw=%b want addr=%h data=%h rw=1",
                         i, log_addr[l0+i], log_wdata[l0+i], log_rw[l0+i], 16'h4001 + 16'(i), wd[i]);
            end
        end
        total++; if (xfer_cnt !== 6'd4) begin bad++; $display("FAIL wr_xfer_cnt: got %0d want 4", xfer_cnt); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL wr_error: got %b want 0", error); end
    endtask

    task automatic test_read_burst();
        int dn; int l0;
        logic [DW-1:0] d;
        for (int i = 0; i < 3; i++) rd_tab[(rd_ptr + i) % 64] = 8'hA0 + 8'(i);
        l0 = log_n;
        run_burst(1'b0, 16'h4001, 6'd3, dn);
        total++; if (dn !== 1) begin bad++; $display("FAIL rd_done: got %0d pulses want 1", dn); end
        total++; if (log_rw[l0] !== 1'b0 || log_addr[l0+2] !== 16'h4003) begin
            bad++; $display("FAIL rd_bus: got rw=%b addr2=%h want rw=0 addr2=4003", log_rw[l0], log_addr[l0+2]);
        end
        for (int i = 0; i < 3; i++) begin
            host_read(BAW'(16 + i), d);
            total++; if (d !== 8'hA0 + 8'(i)) begin
                bad++; $display("FAIL rd_buf%0d: got %h want %h", 16 + i, d, 8'hA0 + 8'(i));
            end
        end
        total++; if (xfer_cnt !== 6'd3) begin bad++; $display("FAIL rd_xfer_cnt: got %0d want 3", xfer_cnt); end
    endtask

    task automatic test_wrap();
        int dn; int l0;
        logic [DW-1:0] d;
        l0 = log_n;
        run_burst(1'b1, 16'hFFFF, 6'd2, dn);
        total++; if (log_addr[l0] !== 16'hFFFF || log_addr[l0+1] !== 16'h0000) begin
            bad++; $display("FAIL wrap_addr: got %h,%h want ffff,0000", log_addr[l0], log_addr[l0+1]);
        end
        // 18 reads from offset 16: results 16 and 17 land at buffer index 0 and 1.
        for (int i = 0; i < 18; i++) rd_tab[(rd_ptr + i) % 64] = 8'hC0 + 8'(i);
        l0 = log_n;
        run_burst(1'b0, 16'h0100, 6'd18, dn);
        total++; if (dn !== 1 || xfer_cnt !== 6'd18) begin
            bad++; $display("FAIL wrap_len18: got done=%0d xfer=%0d want 1,18", dn, xfer_cnt);
        end
        total++; if (log_addr[l0+17] !== 16'h0111) begin
            bad++; $display("FAIL wrap_last_addr: got %h want 0111", log_addr[l0+17]);
        end
        host_read(5'd16, d);
        total++; if (d !== 8'hC0) begin bad++; $display("FAIL wrap_buf16: got %h want c0", d); end
        host_read(5'd31, d);
        total++; if (d !== 8'hCF) begin bad++; $display("FAIL wrap_buf31: got %h want cf", d); end
        host_read(5'd0, d);
        total++; if (d !== 8'hD0) begin bad++; $display("FAIL wrap_buf0: got %h want d0", d); end
        host_read(5'd1, d);
        total++; if (d !== 8'hD1) begin bad++; $display("FAIL wrap_buf1: got %h want d1", d); end
    endtask

    task automatic test_timeout();
        int dn; int v0;
        ms_mode = 1;
        v0 = vcnt;
        run_burst(1'b1, 16'h3000, 6'd2, dn);
        total++; if (vcnt - v0 !== TO) begin bad++; $display("FAIL to_valid_cycles: got %0d want %0d", vcnt - v0, TO); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL to_error: got %b want 1", error); end
        total++; if (dn !== 1) begin bad++; $display("FAIL to_done: got %0d pulses want 1", dn); end
        total++; if (xfer_cnt !== 6'd0) begin bad++; $display("FAIL to_xfer_cnt: got %0d want 0", xfer_cnt); end
        ms_mode = 0;
        rd_tab[rd_ptr % 64] = 8'h5C;
        @(negedge clk);
        mode = 1'b0; base_addr = 16'h3000; burst_len = 6'd1; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        total++; if (error !== 1'b0) begin bad++; $display("FAIL to_clear_on_launch: got %b want 0", error); end
        for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
        total++; if (ready !== 1'b1 || xfer_cnt !== 6'd1 || error !== 1'b0) begin
            bad++; $display("FAIL to_recover: got ready=%b xfer=%0d err=%b want 1,1,0", ready, xfer_cnt, error);
        end
    endtask

    task automatic test_len0_ignored();
        int v0; int dc0; int l0;
        logic [DW-1:0] d;
        v0 = vcnt;
        @(negedge clk);
        mode = 1'b1; burst_len = 6'd0; start = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done: got %b want 1", done); end
        start = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b0 || ready !== 1'b1 || vcnt !== v0) begin
            bad++; $display("FAIL len0_after: got done=%b ready=%b valid_cycles=%0d want 0,1,0", done, ready, vcnt - v0);
        end
        host_write(5'd5, 8'h5A);
        host_write(5'd0, 8'h61);
        host_write(5'd1, 8'h62);
        l0 = log_n; dc0 = done_cnt;
        @(negedge clk);
        mode = 1'b1; base_addr = 16'h2000; burst_len = 6'd2; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; host_we = 1'b1; host_addr = 5'd5; host_wdata = 8'h55;
        @(negedge clk);
        start = 1'b1; host_we = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1 || host_rdata !== 8'h5A) begin
            bad++; $display("FAIL busy_hread: got busy=%b data=%h want 1,5a", busy, host_rdata);
        end
        for (int i = 0; i < 100 && done_cnt == dc0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++; if (done_cnt - dc0 !== 1 || log_n - l0 !== 2) begin
            bad++; $display("FAIL ign_burst: got done=%0d xfers=%0d want 1,2", done_cnt - dc0, log_n - l0);
        end
        total++; if (log_addr[l0+1] !== 16'h2001 || log_wdata[l0] !== 8'h61 || log_wdata[l0+1] !== 8'h62) begin
            bad++; $display("FAIL ign_data: got addr1=%h d0=%h d1=%h want 2001,61,62",
                            log_addr[l0+1], log_wdata[l0], log_wdata[l0+1]);
        end
        host_read(5'd5, d);
        total++; if (d !== 8'h5A) begin bad++; $display("FAIL ign_host_we: got %h want 5a", d); end
    endtask

    task automatic test_reset_mid();
        int dc0; int v0;
        logic found;
        found = 1'b0;
        dc0 = done_cnt;
        @(negedge clk);
        mode = 1'b0; base_addr = 16'h1000; burst_len = 6'd3; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (busy && xfer_cnt == 6'd1 && !m_valid && !m_ready) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_mid_reach_wait: got %b want 1", found); end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b1 || m_valid !== 1'b0 || xfer_cnt !== 6'd0 || error !== 1'b0) begin
            bad++; $display("FAIL rst_mid_state: got ready=%b valid=%b xfer=%0d err=%b want 1,0,0,0",
                            ready, m_valid, xfer_cnt, error);
        end
        rst = 1'b0;
        v0 = vcnt;
        repeat (5) @(negedge clk);
        total++; if (ready !== 1'b1 || vcnt !== v0 || done_cnt !== dc0) begin
            bad++; $display("FAIL rst_mid_quiet: got ready=%b valid_cycles=%0d done=%0d want 1,0,0",
                            ready, vcnt - v0, done_cnt - dc0);
        end
        start = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_timeout();
        test_len0_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
